// File: rtl/fitness_dispatch_if.sv
// Handshake and result bundle between the fitness dispatcher and its environment.
// Latency: none, wires only.
// Backpressure: the route stream is valid/ready; the evaluator uses a start/done pulse pair.
//
// Signals:
//   gen_start            one-cycle request to run a generation
//   route_valid/ready    route stream handshake, route_in is 15 cities x 10 bits
//   eval_start/route     start pulse and held route towards the distance evaluator
//   eval_done/dist       evaluator completion pulse with tour distance
//   gen_done, best_*     generation-complete pulse and the winning route
//   timeout_cnt          routes whose evaluation timed out, saturating
interface fitness_dispatch_if;
  logic         gen_start;
  logic         route_valid;
  logic [149:0] route_in;
  logic         route_ready;
  logic         eval_start;
  logic [149:0] eval_route;
  logic         eval_done;
  logic [11:0]  eval_dist;
  logic         gen_done;
  logic [11:0]  best_dist;
  logic [7:0]   best_idx;
  logic [149:0] best_route;
  logic [7:0]   timeout_cnt;

  // Dispatcher side.
  modport slave (
    input  gen_start, route_valid, route_in, eval_done, eval_dist,
    output route_ready, eval_start, eval_route, gen_done,
           best_dist, best_idx, best_route, timeout_cnt
  );

  // Environment side: route source, evaluator and result consumer.
  modport master (
    output gen_start, route_valid, route_in, eval_done, eval_dist,
    input  route_ready, eval_start, eval_route, gen_done,
           best_dist, best_idx, best_route, timeout_cnt
  );
endinterface

// File: rtl/fitness_dispatch.sv
// Feeds GEN_SIZE routes one at a time to a distance evaluator and keeps the shortest.
// Latency: per route LOAD wait + START + WAIT (eval or TIMEOUT) + UPDATE, plus one REPORT cycle.
// Backpressure: route_ready only in LOAD; evaluator results are accepted only while waiting.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   bus          fitness_dispatch_if.slave (route stream, evaluator, results)
module fitness_dispatch #(
  parameter int GEN_SIZE = 16,
  parameter int TIMEOUT  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  fitness_dispatch_if.slave bus
);

  localparam int         WW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [11:0] DIST_MAX = 12'hFFF;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT, S_UPDATE, S_REPORT
  } state_t;

  state_t         state_q,      state_d;
  logic [7:0]     idx_q,        idx_d;
  logic [WW-1:0]  wait_q,       wait_d;
  logic [11:0]    dist_q,       dist_d;
  logic [149:0]   eval_route_q, eval_route_d;
  logic [11:0]    run_min_q,    run_min_d;
  logic [7:0]     run_idx_q,    run_idx_d;
  logic [149:0]   run_route_q,  run_route_d;
  logic [7:0]     tmo_q,        tmo_d;
  logic [11:0]    best_dist_q,  best_dist_d;
  logic [7:0]     best_idx_q,   best_idx_d;
  logic [149:0]   best_route_q, best_route_d;

  logic route_ready;
  logic eval_start;
  logic gen_done;
  logic take;

  // Route 0 is always taken so an all-timeout generation still reports
  // route 0 rather than a stale route; later routes need a strictly
  // smaller distance, so ties keep the earlier route.
  assign take = (idx_q == 8'd0) || (dist_q < run_min_q);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    wait_d       = wait_q;
    dist_d       = dist_q;
    eval_route_d = eval_route_q;
    run_min_d    = run_min_q;
    run_idx_d    = run_idx_q;
    run_route_d  = run_route_q;
    tmo_d        = tmo_q;
    best_dist_d  = best_dist_q;
    best_idx_d   = best_idx_q;
    best_route_d = best_route_q;
    route_ready  = 1'b0;
    eval_start   = 1'b0;
    gen_done     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.gen_start) begin
          state_d   = S_LOAD;
          idx_d     = 8'd0;
          run_min_d = DIST_MAX;
          run_idx_d = 8'd0;
          tmo_d     = 8'd0;
        end
      end
      S_LOAD: begin
        route_ready = 1'b1;
        if (bus.route_valid) begin
          eval_route_d = bus.route_in;
          state_d      = S_START;
        end
      end
      S_START: begin
        eval_start = 1'b1;
        wait_d     = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (bus.eval_done) begin
          dist_d  = bus.eval_dist;
          state_d = S_UPDATE;
        end else if (wait_q == WW'(TIMEOUT - 1)) begin
          // Unanswered route scores as the worst possible distance.
          dist_d  = DIST_MAX;
          tmo_d   = (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'd1;
          state_d = S_UPDATE;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_UPDATE: begin
        if (take) begin
          run_min_d   = dist_q;
          run_idx_d   = idx_q;
          run_route_d = eval_route_q;
        end
        if (idx_q == 8'(GEN_SIZE - 1)) begin
          state_d = S_REPORT;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = S_LOAD;
        end
      end
      S_REPORT: begin
        gen_done     = 1'b1;
        best_dist_d  = run_min_q;
        best_idx_d   = run_idx_q;
        best_route_d = run_route_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= 8'd0;
      wait_q       <= '0;
      dist_q       <= DIST_MAX;
      eval_route_q <= '0;
      run_min_q    <= DIST_MAX;
      run_idx_q    <= 8'd0;
      run_route_q  <= '0;
      tmo_q        <= 8'd0;
      best_dist_q  <= DIST_MAX;
      best_idx_q   <= 8'd0;
      best_route_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      wait_q       <= wait_d;
      dist_q       <= dist_d;
      eval_route_q <= eval_route_d;
      run_min_q    <= run_min_d;
      run_idx_q    <= run_idx_d;
      run_route_q  <= run_route_d;
      tmo_q        <= tmo_d;
      best_dist_q  <= best_dist_d;
      best_idx_q   <= best_idx_d;
      best_route_q <= best_route_d;
    end
  end

  assign bus.route_ready = route_ready;
  assign bus.eval_start  = eval_start;
  assign bus.gen_done    = gen_done;
  assign bus.eval_route  = eval_route_q;
  assign bus.timeout_cnt = tmo_q;

  // Results are presented alongside the gen_done pulse and then held in the
  // best_* registers until the next REPORT.
  assign bus.best_dist  = (state_q == S_REPORT) ? run_min_q   : best_dist_q;
  assign bus.best_idx   = (state_q == S_REPORT) ? run_idx_q   : best_idx_q;
  assign bus.best_route = (state_q == S_REPORT) ? run_route_q : best_route_q;

endmodule

// File: tb/tb_fitness_dispatch.sv
// Randomized and directed bench for fitness_dispatch with a behavioural model.
// Latency: drives and samples 1ns after each falling edge.
// Backpressure: route_valid delays and evaluator response delays are varied.
module tb_fitness_dispatch;
  localparam int GS = 4;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fitness_dispatch_if bus();

  fitness_dispatch #(.GEN_SIZE(GS), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int gd_cnt = 0;

  // Per-generation stimulus tables.
  logic [11:0]  g_dist  [GS];
  bit           g_ans   [GS];
  int           g_vdly  [GS];
  int           g_edly  [GS];
  logic [149:0] g_route [GS];

  // Results the bench expects the DUT to be holding between generations.
  logic [11:0]  exp_best_dist  = 12'hFFF;
  logic [7:0]   exp_best_idx   = 8'd0;
  logic [149:0] exp_best_route = '0;

  always @(negedge clk) if (bus.gen_done === 1'b1) gd_cnt++;

  task automatic chk(input string tag, input logic [149:0] obs, input logic [149:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(inout int c);
    @(negedge clk);
    #1;
    c++;
  endtask

  function automatic logic [149:0] rand_route();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[149:0];
  endfunction

  task automatic set_defaults();
    for (int i = 0; i < GS; i++) begin
      g_ans[i]   = 1'b1;
      g_vdly[i]  = 0;
      g_edly[i]  = $urandom_range(0, 5);
      g_route[i] = rand_route();
    end
  endtask

  // Reset during a WAIT: everything must read as reset immediately, a late
  // eval_done must be ignored and no gen_done may appear.
  task automatic do_abort(input int gd0);
    int c = 0;
    bit quiet = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_route_ready", bus.route_ready, 1'b0);
    chk("rst_eval_start",  bus.eval_start,  1'b0);
    chk("rst_gen_done",    bus.gen_done,    1'b0);
    chk("rst_best_dist",   bus.best_dist,   12'hFFF);
    chk("rst_best_idx",    bus.best_idx,    8'd0);
    chk("rst_best_route",  bus.best_route,  150'd0);
    chk("rst_eval_route",  bus.eval_route,  150'd0);
    chk("rst_timeout_cnt", bus.timeout_cnt, 8'd0);
    tick(c);
    rst_n = 1'b1;
    bus.eval_done = 1'b1;
    bus.eval_dist = 12'd3;
    tick(c);
    bus.eval_done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (bus.route_ready !== 1'b0 || bus.eval_start !== 1'b0) quiet = 1'b0;
      tick(c);
    end
    chk("abort_idle_quiet", quiet, 1'b1);
    chk("abort_no_gen_done", gd_cnt - gd0, 0);
    exp_best_dist  = 12'hFFF;
    exp_best_idx   = 8'd0;
    exp_best_route = '0;
  endtask

  // Runs one generation from the tables. noise pulses gen_start in WAIT and
  // eval_done in LOAD (needs edly>=1 and vdly>=1); abort_at resets the DUT
  // during the WAIT of that route (needs edly>=3).
  task automatic run_gen(input bit noise, input int abort_at);
    int lat = 0;
    int exp_lat = 1;
    int exp_tmo = 0;
    int w;
    int gd0 = gd_cnt;
    int bi;
    logic [11:0] mn;
    logic [11:0] eff [GS];
    bit ok_load, ok_wait;

    // Model: timed-out routes score 0xFFF; the winner is the first route
    // holding the minimum score.
    mn = 12'hFFF;
    for (int i = 0; i < GS; i++) begin
      eff[i] = g_ans[i] ? g_dist[i] : 12'hFFF;
      if (eff[i] < mn) mn = eff[i];
      if (!g_ans[i]) exp_tmo++;
    end
    bi = 0;
    for (int i = GS - 1; i >= 0; i--) if (eff[i] == mn) bi = i;

    bus.gen_start = 1'b1;
    tick(lat);
    bus.gen_start = 1'b0;

    for (int i = 0; i < GS; i++) begin
      ok_load = 1'b1;
      for (int k = 0; k < g_vdly[i]; k++) begin
        if (bus.route_ready !== 1'b1 || bus.eval_start !== 1'b0) ok_load = 1'b0;
        if (noise && k == 0) begin
          bus.eval_done = 1'b1;
          bus.eval_dist = 12'd1;
        end
        tick(lat);
        bus.eval_done = 1'b0;
      end
      if (bus.route_ready !== 1'b1) ok_load = 1'b0;
      bus.route_valid = 1'b1;
      bus.route_in    = g_route[i];
      tick(lat);
      bus.route_valid = 1'b0;
      bus.route_in    = rand_route();
      chk("load_phase", ok_load, 1'b1);
      chk("eval_start_pulse", {bus.eval_start, bus.route_ready}, 2'b10);
      chk("eval_route_capture", bus.eval_route, g_route[i]);
      tick(lat);

      w = g_ans[i] ? g_edly[i] + 1 : TO;
      exp_lat += g_vdly[i] + 1 + 1 + w + 1;
      ok_wait = 1'b1;
      for (int k = 0; k < w - 1; k++) begin
        if (abort_at == i && k == 2) begin
          do_abort(gd0);
          return;
        end
        if (bus.eval_start !== 1'b0 || bus.eval_route !== g_route[i] ||
            bus.route_ready !== 1'b0 || bus.best_dist !== exp_best_dist ||
            bus.best_idx !== exp_best_idx) ok_wait = 1'b0;
        if (noise && k == 0) bus.gen_start = 1'b1;
        tick(lat);
        bus.gen_start = 1'b0;
      end
      if (bus.eval_start !== 1'b0 || bus.eval_route !== g_route[i]) ok_wait = 1'b0;
      if (g_ans[i]) begin
        bus.eval_done = 1'b1;
        bus.eval_dist = g_dist[i];
      end
      tick(lat);
      bus.eval_done = 1'b0;
      bus.eval_dist = 12'($urandom);
      chk("wait_phase", ok_wait, 1'b1);
      tick(lat);
    end

    chk("gen_done_pulse",  bus.gen_done,    1'b1);
    chk("latency",         lat,             exp_lat);
    chk("best_dist",       bus.best_dist,   mn);
    chk("best_idx",        bus.best_idx,    8'(bi));
    chk("best_route",      bus.best_route,  g_route[bi]);
    chk("timeout_cnt",     bus.timeout_cnt, 8'(exp_tmo));
    exp_best_dist  = mn;
    exp_best_idx   = 8'(bi);
    exp_best_route = g_route[bi];
    tick(lat);
    chk("gen_done_single", bus.gen_done, 1'b0);
    chk("best_hold", {bus.best_dist, bus.best_idx, bus.best_route},
        {exp_best_dist, exp_best_idx, exp_best_route});
    chk("gen_done_count", gd_cnt - gd0, 1);
  endtask

  initial begin
    int c = 0;
    rst_n           = 1'b0;
    bus.gen_start   = 1'b0;
    bus.route_valid = 1'b0;
    bus.route_in    = '0;
    bus.eval_done   = 1'b0;
    bus.eval_dist   = '0;
    tick(c);
    tick(c);
    chk("reset_outputs",
        {bus.route_ready, bus.eval_start, bus.gen_done, bus.timeout_cnt},
        {1'b0, 1'b0, 1'b0, 8'd0});
    chk("reset_best", {bus.best_dist, bus.best_idx, bus.best_route, bus.eval_route},
        {12'hFFF, 8'd0, 150'd0, 150'd0});
    rst_n = 1'b1;
    tick(c);

    // Basic minimum search.
    set_defaults();
    g_dist = '{12'd300, 12'd120, 12'd500, 12'd200};
    run_gen(1'b0, -1);

    // Tie keeps the earlier route.
    set_defaults();
    g_dist = '{12'd200, 12'd150, 12'd150, 12'd400};
    run_gen(1'b0, -1);

    // Route 2 never answered: full timeout, small dist must not be used.
    set_defaults();
    g_dist = '{12'd400, 12'd300, 12'd50, 12'd350};
    g_ans[2] = 1'b0;
    run_gen(1'b0, -1);

    // route_valid withheld 10 cycles in LOAD.
    set_defaults();
    g_dist = '{12'd300, 12'd120, 12'd500, 12'd200};
    g_vdly[1] = 10;
    run_gen(1'b0, -1);

    // Stray gen_start in WAIT and eval_done in LOAD are ignored.
    set_defaults();
    g_dist = '{12'd300, 12'd120, 12'd500, 12'd200};
    for (int i = 0; i < GS; i++) begin
      g_vdly[i] = 2;
      g_edly[i] = 3;
    end
    run_gen(1'b1, -1);

    // All routes time out: 0xFFF, index 0, route 0.
    set_defaults();
    g_dist = '{12'd10, 12'd20, 12'd30, 12'd40};
    for (int i = 0; i < GS; i++) g_ans[i] = 1'b0;
    run_gen(1'b0, -1);

    // Reset during the WAIT of route 2, after a generation with a timeout.
    set_defaults();
    g_dist = '{12'd100, 12'd90, 12'd80, 12'd70};
    g_ans[3] = 1'b0;
    run_gen(1'b0, -1);
    set_defaults();
    g_dist = '{12'd100, 12'd90, 12'd80, 12'd70};
    g_edly[2] = 8;
    run_gen(1'b0, 2);

    // Randomized generations, with a small value pool to force ties.
    for (int g = 0; g < 20; g++) begin
      set_defaults();
      for (int i = 0; i < GS; i++) begin
        if ($urandom_range(0, 2) == 0)
          g_dist[i] = 12'(100 * $urandom_range(1, 3));
        else
          g_dist[i] = 12'($urandom_range(0, 4095));
        g_ans[i]  = ($urandom_range(0, 5) != 0);
        g_vdly[i] = $urandom_range(0, 3);
        g_edly[i] = $urandom_range(1, 8);
      end
      run_gen(($urandom_range(0, 3) == 0) && (g_vdly[0] > 0) && (g_vdly[1] > 0) &&
              (g_vdly[2] > 0) && (g_vdly[3] > 0), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
